seg_to_hex_capture: RTL and testbench

//  Inverse of the hex-to-7-seg decoder. Samples an active-low {A,B,C,D,E,F,G} segment bus,

---
 rtl/seg_to_hex_capture_pkg.sv | 29 ++
 rtl/seg_to_hex_capture_encoder.sv | 37 +++
 rtl/seg_to_hex_capture.sv | 135 +++++++++++++
 tb/tb_seg_to_hex_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_to_hex_capture_pkg.sv
// Shared 7-segment glyph constants and FSM state type for the segment capture path.
// Glyphs are {A,B,C,D,E,F,G}, active-low, A in bit 6.
// The hex-to-7-seg decoder imports the same constants so the two directions cannot diverge.
package seg_to_hex_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/seg_to_hex_capture_encoder.sv
// Purpose: map a 7-bit active-low segment pattern back to its hex digit.
// Latency: combinational.
// Backpressure: none; unknown patterns (including BLANK) flag illegal with hex=0.
module seg_pattern_encoder
  import seg_to_hex_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       illegal,
  output logic [3:0] hex
);

  // Reverse glyph lookup; anything outside the 16 legal glyphs is illegal.
  always_comb begin
    illegal = 1'b0;
    hex     = 4'h0;
    case (pattern)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_to_hex_capture.sv
// Purpose: debounce a sampled active-low 7-seg bus and report each newly stable digit once.
// Latency: pattern constant from enabled edge 1 -> out_valid after edge STABLE_CYCLES+1.
// Backpressure: result frozen in HOLD until out_valid&out_ready; a newer stable pattern sets sticky overrun.
module seg_to_hex_capture
  import seg_to_hex_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_n,
  input  logic       seg_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] hex,
  output logic       illegal,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [6:0]       sample_q;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       last_q;
  logic [6:0]       last_d;
  state_t           state_q;
  state_t           state_d;
  logic             valid_q;
  logic             valid_d;
  logic [3:0]       hex_q;
  logic [3:0]       hex_d;
  logic             illegal_q;
  logic             illegal_d;
  logic             overrun_q;
  logic             overrun_d;

  logic             enc_illegal;
  logic [3:0]       enc_hex;
  logic             new_stable;

  seg_pattern_encoder u_encoder (
    .pattern (sample_q),
    .illegal (enc_illegal),
    .hex     (enc_hex)
  );

  // A pattern qualifies once it has been seen STABLE_CYCLES times in a row and was not the last one handled.
  assign new_stable = (cnt_q == CNT_STABLE) && (sample_q != last_q);

  // Sample register and saturating run-length counter, advanced only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= SEG_BLANK;
      cnt_q    <= '0;
    end else if (seg_en) begin
      sample_q <= seg_n;
      if (seg_n != sample_q) begin
        cnt_q <= CNT_ONE;
      end else if (cnt_q != CNT_STABLE) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus result/overrun updates; BLANK is absorbed into last_q without producing a result.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    valid_d   = valid_q;
    hex_d     = hex_q;
    illegal_d = illegal_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (new_stable) begin
          last_d = sample_q;
          if (sample_q != SEG_BLANK) begin
            hex_d     = enc_hex;
            illegal_d = enc_illegal;
            valid_d   = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // last_q is the held pattern here, so one compare covers both "differs" conditions.
        if (new_stable) begin
          overrun_d = 1'b1;
        end
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Result, last-reported and sticky overrun registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= SEG_BLANK;
      valid_q   <= 1'b0;
      hex_q     <= 4'h0;
      illegal_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      valid_q   <= valid_d;
      hex_q     <= hex_d;
      illegal_q <= illegal_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign hex       = hex_q;
  assign illegal   = illegal_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_to_hex_capture.sv
// Self-checking bench for seg_to_hex_capture: glyph table vectors, directed corner sequences,
// and randomized segment traffic against a run-length based reference model.
module tb_seg_to_hex_capture;

  localparam int S = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_n = 7'b1111111;
  logic       seg_en = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] hex;
  logic       illegal;
  logic       overrun;

  always #5 clk = ~clk;

  seg_to_hex_capture #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_n     (seg_n),
    .seg_en    (seg_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hex       (hex),
    .illegal   (illegal),
    .overrun   (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] glyph [16];

  typedef struct {
    logic [6:0] seg;
    int         n_res;
    logic [3:0] exp_hex;
    bit         exp_ill;
  } vec_t;
  vec_t tbl [18];

  // Reference model: pattern history as a run length plus the last handled pattern.
  logic [6:0] m_samp;
  logic [6:0] m_last;
  int         m_run;
  bit         m_valid;
  logic [3:0] m_hex;
  bit         m_ill;
  bit         m_ovr;

  int rx_hex [$];
  bit rx_ill [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_samp  = BLANK;
    m_last  = BLANK;
    m_run   = 0;
    m_valid = 0;
    m_hex   = 4'h0;
    m_ill   = 0;
    m_ovr   = 0;
  endfunction

  function automatic void decode(input logic [6:0] p, output logic [3:0] h, output bit il);
    il = 1;
    h  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == p) begin
        il = 0;
        h  = 4'(i);
      end
    end
  endfunction

  function automatic void model_edge(input logic [6:0] s, input bit en, input bit rdy);
    bit fresh;
    fresh = (m_run >= S) && (m_samp != m_last);
    if (!m_valid) begin
      if (fresh) begin
        m_last = m_samp;
        if (m_samp != BLANK) begin
          decode(m_samp, m_hex, m_ill);
          m_valid = 1;
        end
      end
    end else begin
      if (fresh) m_ovr = 1;
      if (rdy) m_valid = 0;
    end
    if (en) begin
      if (s == m_samp) m_run = (m_run < S) ? m_run + 1 : S;
      else m_run = 1;
      m_samp = s;
    end
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("hex", hex, m_hex);
    chk("illegal", illegal, m_ill);
    chk("overrun", overrun, m_ovr);
  endtask

  // Drive one cycle of inputs, log any transfer, clock, then compare against the model.
  task automatic tick(input logic [6:0] s, input bit en, input bit rdy);
    seg_n     = s;
    seg_en    = en;
    out_ready = rdy;
    #1;
    if (out_valid && out_ready) begin
      rx_hex.push_back(int'(hex));
      rx_ill.push_back(illegal);
    end
    @(posedge clk);
    model_edge(s, en, rdy);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    rx_hex.delete();
    rx_ill.delete();
  endtask

  initial begin
    glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    for (int i = 0; i < 16; i++) begin
      tbl[i].seg     = glyph[i];
      tbl[i].n_res   = 1;
      tbl[i].exp_hex = 4'(i);
      tbl[i].exp_ill = 0;
    end
    tbl[16] = '{seg: 7'b1111110, n_res: 1, exp_hex: 4'h0, exp_ill: 1'b1};
    tbl[17] = '{seg: BLANK,      n_res: 0, exp_hex: 4'h0, exp_ill: 1'b0};

    model_reset();
    #2;
    do_reset();
    chk("reset_valid", out_valid, 0);
    chk("reset_overrun", overrun, 0);

    // Digit 5 held: first valid after edge 5, transferred on edge 6.
    for (int k = 1; k <= 7; k++) begin
      tick(glyph[5], 1, 1);
      chk($sformatf("t1_valid_edge%0d", k), out_valid, (k == 5) ? 1 : 0);
      if (k == 5) begin
        chk("t1_hex", hex, 5);
        chk("t1_illegal", illegal, 0);
      end
    end

    // Glyph table, one illegal pattern and BLANK, each followed by BLANK.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      rx_hex.delete();
      rx_ill.delete();
      repeat (6) tick(tbl[i].seg, 1, 1);
      repeat (6) tick(BLANK, 1, 1);
      chk($sformatf("t2_count_%0d", i), rx_hex.size(), tbl[i].n_res);
      if (rx_hex.size() > 0) begin
        chk($sformatf("t2_hex_%0d", i), rx_hex[0], tbl[i].exp_hex);
        chk($sformatf("t2_ill_%0d", i), rx_ill[0], tbl[i].exp_ill);
      end
    end

    // 8/9 chatter never settles; then 9 settles and is reported exactly once.
    rx_hex.delete();
    for (int i = 0; i < 20; i++) tick(glyph[(i % 2 == 0) ? 8 : 9], 1, 1);
    chk("t4_chatter_none", rx_hex.size(), 0);
    repeat (8) tick(glyph[9], 1, 1);
    chk("t4_one_result", rx_hex.size(), 1);
    if (rx_hex.size() > 0) chk("t4_hex", rx_hex[0], 9);
    repeat (20) tick(glyph[9], 1, 1);
    chk("t4_still_one", rx_hex.size(), 1);

    // Backpressure: 3 held while 7 settles -> overrun, then 3 and 7 in order.
    do_reset();
    repeat (6) tick(glyph[3], 1, 0);
    chk("t5_valid", out_valid, 1);
    chk("t5_hex3", hex, 3);
    repeat (6) tick(glyph[7], 1, 0);
    chk("t5_hex_frozen", hex, 3);
    chk("t5_overrun", overrun, 1);
    chk("t5_no_transfer", rx_hex.size(), 0);
    repeat (4) tick(glyph[7], 1, 1);
    chk("t5_count", rx_hex.size(), 2);
    if (rx_hex.size() == 2) begin
      chk("t5_first", rx_hex[0], 3);
      chk("t5_second", rx_hex[1], 7);
    end
    repeat (5) tick(glyph[7], 1, 1);
    chk("t5_overrun_sticky", overrun, 1);
    do_reset();
    chk("t5_overrun_cleared", overrun, 0);

    // Long hold of 2 gives one result.
    repeat (40) tick(glyph[2], 1, 1);
    chk("t6_long_hold", rx_hex.size(), 1);
    if (rx_hex.size() > 0) chk("t6_hex2", rx_hex[0], 2);

    // seg_en low freezes the count even while seg_n wanders.
    do_reset();
    repeat (2) tick(glyph[4], 1, 1);
    repeat (10) tick(glyph[6], 0, 1);
    tick(glyph[4], 1, 1);
    chk("t6_frozen_3", out_valid, 0);
    tick(glyph[4], 1, 1);
    chk("t6_frozen_4", out_valid, 0);
    tick(glyph[4], 1, 0);
    chk("t6_valid_after_en", out_valid, 1);
    chk("t6_hex4", hex, 4);

    // Asynchronous reset while holding drops the result without a clock edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [6:0] p;
      int r;
      int len;
      r = $urandom_range(0, 9);
      if (r < 6) p = glyph[$urandom_range(0, 15)];
      else if (r < 8) p = BLANK;
      else p = 7'($urandom);
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        tick(p, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
